imem_fill_responder: RTL and testbench
======================================

Name: imem_fill_responder

Overview:
- Backing instruction-memory responder that serves line-fill requests issued by the L1 instruction cache on a cache miss.
- Holds a 2^ADDR_W-word instruction store, preloadable through a program port.
- Accepts one line request at a time, waits a fixed access latency, then returns LINE_WORDS 32-bit words as a valid/ready burst.
- Sits between l1_cache (the requester) and the bench/boot loader (the program port).

Parameters:
ADDR_W, 6, word-address width; matches the 6-bit instruction fetch address.
LINE_WORDS, 4, words per line; power of two, 2..16.
LATENCY, 3, cycles from request accept to first beat valid; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
clk_en  input  1  global advance enable; when low, all state holds and no handshake completes.
req_valid  input  1  line request valid.
req_ready  output  1  request accepted when req_valid & req_ready; equals (state==IDLE) & clk_en.
req_addr  input  ADDR_W  requested word address; low log2(LINE_WORDS) bits are ignored.
resp_valid  output  1  response beat valid; registered.
resp_ready  input  1  cache accepts beat.
resp_data  output  32  beat data; registered.
resp_last  output  1  high with the final beat of a line.
misalign  output  1  one-cycle pulse on accept when req_addr low bits are nonzero.
busy  output  1  state != IDLE.
prog_we  input  1  store write enable; qualified by clk_en.
prog_addr  input  ADDR_W  store write address.
prog_data  input  32  store write data.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; resp_valid=0, resp_last=0, resp_data=0, misalign=0, busy=0; internal counters=0.
  - The store contents are NOT cleared.
  - Reset mid-burst abandons the burst; no further beats are sent.
- FSM:
  - IDLE: on accept, latch base = req_addr with low bits forced to 0; cnt = LATENCY-1; go to WAIT. misalign is registered high for that one cycle if req_addr low bits were nonzero.
  - WAIT: if cnt==0, at the next edge load beat 0 (resp_data = mem[base], resp_valid=1, resp_last = (LINE_WORDS==1)), idx=0, go to BURST. Otherwise decrement cnt.
  - BURST: resp_data and resp_last hold while resp_valid & !resp_ready.
    - On a handshake that is not the last beat: at that edge load mem[base+idx+1] and increment idx. There is no bubble between beats.
    - On the last-beat handshake: resp_valid=0, resp_last=0, go to IDLE.
- Latency: accept at edge N gives resp_valid visible after edge N+LATENCY, provided clk_en stays high. Each cycle with clk_en low extends this by one cycle.
- Beat addresses are base..base+LINE_WORDS-1 and never wrap outside the line. The top line of the store is legal.
- A new request cannot be accepted in the same cycle as the last beat handshake. The earliest accept is the following cycle.
- clk_en low:
  - No accept, no handshake, no prog write; all registers hold.
  - req_ready=0. resp_valid stays asserted if set, but is not consumed.
- Program port:
  - Synchronous write at a rising edge when prog_we & clk_en.
  - Legal in any state, including during a burst.
  - A beat load and a write to the same address in the same edge return the old data (read-before-write).
  - A write to a not-yet-loaded beat address is visible in that later beat.
- Width: base+idx is computed in ADDR_W bits; because base is line-aligned, no overflow occurs.

Test Plan:
- Preload mem[8..11] = 0x3C010001, 0x3C020002, 0x00221820, 0x3C03FFFF. Request addr 8 at edge N with resp_ready=1 -> resp_valid rises after edge N+3; the four words appear on consecutive cycles; resp_last only on 0x3C03FFFF; req_ready=1 the cycle after.
- Same line with resp_ready low for 2 cycles during beat 1 -> resp_data holds 0x3C020002 for 3 cycles, resp_last=0, then beats 2 and 3 follow with no gap.
- Request addr 0x0A -> misalign pulses for 1 cycle; beats are returned from addr 8..11, identical to the first scenario.
- Drop clk_en for 3 cycles during WAIT -> first beat arrives after edge N+6; no state changes while clk_en is low.
- Assert rst low after beat 1 is accepted -> resp_valid, resp_last and resp_data go to 0 immediately; after release, req_ready=1 and a request to addr 8 returns the intact contents 0x3C010001...
- Request the top line, addr 60 (store preloaded with 60..63 = 0xA0..0xA3), with a prog_we to addr 62 = 0xDEAD in the same cycle beat 1 loads -> beats are 0xA0, 0xA1, 0xDEAD, 0xA3; last on 0xA3; there is no access to addr 0.

Source files
------------

// File: rtl/imem_fill_responder.sv
// Backing instruction store that answers L1 I-cache line fills
// with a fixed access latency followed by a valid/ready burst.
module imem_fill_responder #(
  parameter int ADDR_W     = 6,
  parameter int LINE_WORDS = 4,
  parameter int LATENCY    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic              resp_last,
  output logic              misalign,
  output logic              busy,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam logic [OFF_W-1:0] IDX_LAST = OFF_W'(LINE_WORDS - 1);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [OFF_W-1:0]  idx_q, idx_d;
  logic [OFF_W-1:0]  idx_inc;
  logic [3:0]        cnt_q, cnt_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_last_q, resp_last_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              misalign_q, misalign_d;
  logic              busy_q, busy_d;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  // Base is line-aligned, so OR-ing the offset never carries out of the line.
  assign idx_inc = idx_q + OFF_W'(1);
  assign rd_addr = (state_q == S_BURST) ?
                   (base_q | ADDR_W'(idx_inc)) : base_q;
  assign rd_data = mem[rd_addr];

  assign req_ready  = (state_q == S_IDLE) && clk_en;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_last  = resp_last_q;
  assign misalign   = misalign_q;
  assign busy       = busy_q;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_last_d  = resp_last_q;
    resp_data_d  = resp_data_q;
    misalign_d   = misalign_q;
    busy_d       = busy_q;
    if (clk_en) begin
      misalign_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            base_d     = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            cnt_d      = CNT_INIT;
            misalign_d = |req_addr[OFF_W-1:0];
            busy_d     = 1'b1;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            resp_data_d  = rd_data;
            resp_valid_d = 1'b1;
            resp_last_d  = (LINE_WORDS == 1);
            idx_d        = '0;
            state_d      = S_BURST;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_BURST: begin
          if (resp_ready) begin
            if (idx_q == IDX_LAST) begin
              resp_valid_d = 1'b0;
              resp_last_d  = 1'b0;
              busy_d       = 1'b0;
              state_d      = S_IDLE;
            end else begin
              resp_data_d = rd_data;
              idx_d       = idx_inc;
              resp_last_d = (idx_inc == IDX_LAST);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_last_q  <= 1'b0;
      resp_data_q  <= '0;
      misalign_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_last_q  <= resp_last_d;
      resp_data_q  <= resp_data_d;
      misalign_q   <= misalign_d;
      busy_q       <= busy_d;
    end
  end

  // Store survives reset; reads are combinational so same-edge writes lose.
  always_ff @(posedge clk) begin
    if (prog_we && clk_en) begin
      mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_imem_fill_responder.sv
// Bench for imem_fill_responder: directed vector table, corner
// sequences and randomized traffic against a transaction-level model.
module tb_imem_fill_responder;

  localparam int AW  = 6;
  localparam int LW  = 4;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_en = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [31:0]   resp_data;
  logic          resp_last;
  logic          misalign;
  logic          busy;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;

  imem_fill_responder #(
    .ADDR_W(AW), .LINE_WORDS(LW), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_last(resp_last),
    .misalign(misalign), .busy(busy),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: store image, pending beat addresses, current beat.
  logic [31:0] mm [64];
  int          m_q [$];
  int          m_wait;
  bit          m_valid, m_last, m_mis;
  logic [31:0] m_data;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wait  = 0;
    m_valid = 0;
    m_last  = 0;
    m_mis   = 0;
    m_data  = '0;
  endtask

  function automatic bit m_idle();
    return !m_valid && m_wait == 0;
  endfunction

  task automatic load_next();
    int a;
    a = m_q.pop_front();
    m_data  = mm[a];
    m_last  = (m_q.size() == 0);
    m_valid = 1;
  endtask

  task automatic model_edge();
    int base;
    if (!clk_en) return;
    if (rst) begin
      m_mis = 0;
      if (m_valid) begin
        if (resp_ready) begin
          if (m_q.size() == 0) begin
            m_valid = 0;
            m_last  = 0;
          end else begin
            load_next();
          end
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) load_next();
      end else if (req_valid) begin
        base = (int'(req_addr) / LW) * LW;
        for (int i = 0; i < LW; i++) m_q.push_back(base + i);
        m_wait = LAT;
        m_mis  = (int'(req_addr) % LW) != 0;
      end
    end
    if (prog_we) mm[prog_addr] = prog_data;
  endtask

  task automatic check_all();
    chk("resp_valid", 32'(resp_valid), 32'(m_valid));
    chk("resp_last", 32'(resp_last), 32'(m_last));
    chk("misalign", 32'(misalign), 32'(m_mis));
    chk("busy", 32'(busy), 32'(!m_idle()));
    chk("req_ready", 32'(req_ready), 32'(m_idle() && clk_en));
    if (m_valid) chk("resp_data", resp_data, m_data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic prog(int a, logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic drain();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    clk_en     = 1'b1;
    for (int i = 0; i < 40 && busy; i++) step();
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic collect(output logic [31:0] d [4],
                         output logic l [4], output int got);
    got = 0;
    for (int i = 0; i < 40 && got < LW; i++) begin
      if (resp_valid) begin
        d[got] = resp_data;
        l[got] = resp_last;
        got++;
      end
      step();
    end
  endtask

  task automatic chk_line(string nm, logic [31:0] d [4],
                          logic l [4], int got,
                          logic [31:0] e [4]);
    chk({nm, "_count"}, 32'(got), 32'(LW));
    for (int i = 0; i < LW; i++) begin
      chk($sformatf("%s_data%0d", nm, i), d[i], e[i]);
      chk($sformatf("%s_last%0d", nm, i), 32'(l[i]), 32'(i == LW - 1));
    end
  endtask

  typedef struct {
    bit          rv;
    logic [5:0]  ra;
    bit          rr;
    bit          ce;
    bit          ev;
    logic [31:0] ed;
    bit          el;
    bit          erdy;
  } vec_t;

  vec_t        tbl [18];
  logic [31:0] bd [4];
  logic        bl [4];
  logic [31:0] line8 [4];
  logic [31:0] exp6 [4];
  int          got;
  int          n;

  initial begin
    model_reset();
    foreach (mm[i]) mm[i] = 'x;
    line8 = '{32'h3C010001, 32'h3C020002, 32'h00221820, 32'h3C03FFFF};

    tbl[0]  = '{1, 6'd8, 1, 1, 0, 32'h0, 0, 0};
    tbl[1]  = '{0, 6'd0, 1, 1, 0, 32'h0, 0, 0};
    tbl[2]  = '{0, 6'd0, 1, 1, 0, 32'h0, 0, 0};
    tbl[3]  = '{0, 6'd0, 1, 1, 1, 32'h3C010001, 0, 0};
    tbl[4]  = '{0, 6'd0, 1, 1, 1, 32'h3C020002, 0, 0};
    tbl[5]  = '{0, 6'd0, 1, 1, 1, 32'h00221820, 0, 0};
    tbl[6]  = '{0, 6'd0, 1, 1, 1, 32'h3C03FFFF, 1, 0};
    tbl[7]  = '{0, 6'd0, 1, 1, 0, 32'h0, 0, 1};
    tbl[8]  = '{1, 6'd8, 1, 1, 0, 32'h0, 0, 0};
    tbl[9]  = '{0, 6'd0, 1, 1, 0, 32'h0, 0, 0};
    tbl[10] = '{0, 6'd0, 1, 1, 0, 32'h0, 0, 0};
    tbl[11] = '{0, 6'd0, 1, 1, 1, 32'h3C010001, 0, 0};
    tbl[12] = '{0, 6'd0, 1, 1, 1, 32'h3C020002, 0, 0};
    tbl[13] = '{0, 6'd0, 0, 1, 1, 32'h3C020002, 0, 0};
    tbl[14] = '{0, 6'd0, 0, 1, 1, 32'h3C020002, 0, 0};
    tbl[15] = '{0, 6'd0, 1, 1, 1, 32'h00221820, 0, 0};
    tbl[16] = '{0, 6'd0, 1, 1, 1, 32'h3C03FFFF, 1, 0};
    tbl[17] = '{0, 6'd0, 1, 1, 0, 32'h0, 0, 1};

    // Reset state
    #12;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_last", 32'(resp_last), 32'd0);
    chk("rst_data", resp_data, 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready_ce0", 32'(req_ready), 32'd0);
    clk_en = 1'b1;
    #1;
    chk("rst_ready_ce1", 32'(req_ready), 32'd1);
    rst = 1'b1;

    for (int a = 0; a < 64; a++) prog(a, $urandom);
    for (int i = 0; i < LW; i++) prog(8 + i, line8[i]);
    for (int i = 0; i < LW; i++) prog(60 + i, 32'hA0 + 32'(i));

    // Basic line and back-pressured line
    for (int i = 0; i < 18; i++) begin
      req_valid  = tbl[i].rv;
      req_addr   = tbl[i].ra;
      resp_ready = tbl[i].rr;
      clk_en     = tbl[i].ce;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(resp_valid), 32'(tbl[i].ev));
      if (tbl[i].ev)
        chk($sformatf("tbl%0d_data", i), resp_data, tbl[i].ed);
      chk($sformatf("tbl%0d_last", i), 32'(resp_last), 32'(tbl[i].el));
      chk($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].erdy));
    end
    drain();

    // Misaligned request
    req_valid = 1'b1;
    req_addr  = 6'h0A;
    step();
    req_valid = 1'b0;
    chk("mis_pulse", 32'(misalign), 32'd1);
    step();
    chk("mis_clear", 32'(misalign), 32'd0);
    collect(bd, bl, got);
    chk_line("mis_line", bd, bl, got, line8);
    drain();

    // clk_en stall during WAIT
    req_valid = 1'b1;
    req_addr  = 6'd8;
    step();
    req_valid = 1'b0;
    clk_en    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_busy", 32'(busy), 32'd1);
    end
    clk_en = 1'b1;
    n = 3;
    while (!resp_valid && n < 20) begin
      step();
      n++;
    end
    chk("stall_latency", 32'(n), 32'd6);
    chk("stall_beat0", resp_data, 32'h3C010001);
    drain();

    // Top line with concurrent program writes
    exp6 = '{32'hA0, 32'hA1, 32'hDEAD, 32'hA3};
    req_valid = 1'b1;
    req_addr  = 6'd60;
    step();
    req_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && got < LW; i++) begin
      prog_we = 1'b0;
      if (resp_valid) begin
        bd[got] = resp_data;
        bl[got] = resp_last;
        if (got == 0) begin
          prog_we = 1'b1; prog_addr = 6'd62; prog_data = 32'hDEAD;
        end
        if (got == 2) begin
          prog_we = 1'b1; prog_addr = 6'd63; prog_data = 32'hBEEF;
        end
        got++;
      end
      step();
    end
    prog_we = 1'b0;
    chk_line("top", bd, bl, got, exp6);
    drain();
    exp6 = '{32'hA0, 32'hA1, 32'hDEAD, 32'hBEEF};
    req_valid = 1'b1;
    req_addr  = 6'd61;
    step();
    req_valid = 1'b0;
    collect(bd, bl, got);
    chk_line("top_again", bd, bl, got, exp6);
    drain();

    // Reset mid-burst
    req_valid = 1'b1;
    req_addr  = 6'd8;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !resp_valid; i++) step();
    step();
    step();
    chk("pre_rst_beat2", resp_data, 32'h00221820);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_last", 32'(resp_last), 32'd0);
    chk("mid_rst_data", resp_data, 32'd0);
    step();
    rst = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = 6'd8;
    step();
    req_valid = 1'b0;
    collect(bd, bl, got);
    chk_line("post_rst", bd, bl, got, line8);
    drain();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      clk_en     = ($urandom_range(0, 9) != 0);
      req_valid  = $urandom_range(0, 1) == 1;
      req_addr   = AW'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      prog_we    = ($urandom_range(0, 7) == 0);
      prog_addr  = AW'($urandom);
      prog_data  = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        prog_we = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        step();
        rst = 1'b1;
      end else begin
        step();
      end
    end
    prog_we = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
